// File: rtl/sys_array_feeder_pkg.sv
// Shared definitions for the 2x2 systolic-array operand feeder: state
// encoding, default element width and the length of the skewed load burst.
package sys_array_feeder_pkg;

    localparam int DATA_W_DEFAULT  = 32;
    localparam int TIMEOUT_DEFAULT = 64;

    // Number of cycles the feeder drives load_in for one 2x2 product.
    localparam int FEED_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED0 = 3'd1,
        ST_FEED1 = 3'd2,
        ST_FEED2 = 3'd3,
        ST_WAIT  = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    // True in the three cycles that push operands into the array.
    function automatic logic is_feed(input state_e s);
        return (s == ST_FEED0) || (s == ST_FEED1) || (s == ST_FEED2);
    endfunction

endpackage

// File: rtl/sys_array_feeder_if.sv
// Operand handshake, skewed streams and completion signals between the
// host/array side (master) and the feeder (slave).
interface sys_array_feeder_if
    import sys_array_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    // Operand handshake
    logic              start_valid;
    logic              start_ready;
    logic [DATA_W-1:0] a00, a01, a10, a11;
    logic [DATA_W-1:0] b00, b01, b10, b11;

    // Skewed streams towards the array
    logic              load_in;
    logic [DATA_W-1:0] row_in_row0, row_in_row1;
    logic [DATA_W-1:0] col_in_col0, col_in_col1;

    // Completion and status
    logic              arr_done;
    logic              busy;
    logic              mat_done;
    logic              timeout_err;

    modport master (
        output start_valid, a00, a01, a10, a11, b00, b01, b10, b11, arr_done,
        input  start_ready, load_in, row_in_row0, row_in_row1,
               col_in_col0, col_in_col1, busy, mat_done, timeout_err
    );

    modport slave (
        input  start_valid, a00, a01, a10, a11, b00, b01, b10, b11, arr_done,
        output start_ready, load_in, row_in_row0, row_in_row1,
               col_in_col0, col_in_col1, busy, mat_done, timeout_err
    );

endinterface

// File: rtl/sys_array_feeder.sv
// Captures a 2x2 A/B operand pair, streams it into a 2x2 systolic array
// with the diagonal skew the array expects, then waits for the array's done
// pulse (bounded by TIMEOUT cycles) and reports completion or timeout.
module sys_array_feeder
    import sys_array_feeder_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    sys_array_feeder_if.slave bus
);

    // One extra bit so that TIMEOUT itself is representable.
    localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_e                   state_q, state_d;

    // Holding registers, element order [0]=x00 [1]=x01 [2]=x10 [3]=x11.
    logic [3:0][DATA_W-1:0]   a_q, a_d;
    logic [3:0][DATA_W-1:0]   b_q, b_d;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     expire;

    logic                     load_q, load_d;
    logic [DATA_W-1:0]        row0_q, row0_d;
    logic [DATA_W-1:0]        row1_q, row1_d;
    logic [DATA_W-1:0]        col0_q, col0_d;
    logic [DATA_W-1:0]        col1_q, col1_d;
    logic                     mat_done_q, mat_done_d;
    logic                     timeout_q, timeout_d;

    assign expire = (cnt_q == CNT_LAST);

    // Next-state and operand capture; operands are taken only on acceptance.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    state_d = ST_FEED0;
                    a_d     = {bus.a11, bus.a10, bus.a01, bus.a00};
                    b_d     = {bus.b11, bus.b10, bus.b01, bus.b00};
                end
            end
            ST_FEED0: state_d = ST_FEED1;
            ST_FEED1: state_d = ST_FEED2;
            ST_FEED2: state_d = ST_WAIT;
            ST_WAIT: begin
                // A done pulse on the expiry cycle still counts as success.
                if (bus.arr_done) begin
                    state_d = ST_FIN;
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // WAIT-cycle counter: zero outside WAIT (so it starts at 0 on entry),
    // saturating instead of wrapping while in WAIT.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_WAIT) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Registered stream values, decoded from the state being entered so the
    // streams line up with the state they belong to.
    always_comb begin
        load_d     = is_feed(state_d);
        mat_done_d = (state_d == ST_FIN);
        row0_d     = '0;
        row1_d     = '0;
        col0_d     = '0;
        col1_d     = '0;
        case (state_d)
            ST_FEED0: begin
                row0_d = a_d[0];
                col0_d = b_d[0];
            end
            ST_FEED1: begin
                row0_d = a_d[1];
                col0_d = b_d[2];
                row1_d = a_d[2];
                col1_d = b_d[1];
            end
            ST_FEED2: begin
                row1_d = a_d[3];
                col1_d = b_d[3];
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding registers, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the holding registers are plain flops, not a memory, so they
        // are cleared by reset like everything else.
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            load_q     <= 1'b0;
            row0_q     <= '0;
            row1_q     <= '0;
            col0_q     <= '0;
            col1_q     <= '0;
            mat_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            load_q     <= load_d;
            row0_q     <= row0_d;
            row1_q     <= row1_d;
            col0_q     <= col0_d;
            col1_q     <= col1_d;
            mat_done_q <= mat_done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.load_in     = load_q;
    assign bus.row_in_row0 = row0_q;
    assign bus.row_in_row1 = row1_q;
    assign bus.col_in_col0 = col0_q;
    assign bus.col_in_col1 = col1_q;
    assign bus.mat_done    = mat_done_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Scoreboard bench for sys_array_feeder: the driver pushes expected stream
// beats, products and completion events; two monitors pop and compare.
module tb_sys_array_feeder;
    import sys_array_feeder_pkg::*;

    localparam int TIMEOUT = 64;

    typedef logic [3:0][31:0] mat_t;  // [0]=x00 [1]=x01 [2]=x10 [3]=x11

    typedef struct {
        int          cyc;
        logic [31:0] r0, c0, r1, c1;
    } feed_t;

    typedef struct {
        int cyc;
        bit done;
    } end_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    feed_t        feed_q[$];
    end_t         end_q[$];
    logic [127:0] prod_q[$];

    logic [31:0]  cap_row [2][3];
    logic [31:0]  cap_col [2][3];
    int           cap_n = 0;

    sys_array_feeder_if #(.DATA_W(32)) ifc ();

    sys_array_feeder #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mat_t mk(input int x00, input int x01, input int x10, input int x11);
        mat_t m;
        m[0] = x00; m[1] = x01; m[2] = x10; m[3] = x11;
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < 4; i++) m[i] = $urandom_range(0, 255);
        return m;
    endfunction

    // Golden 2x2 output-stationary array: PE(i,j) at time t multiplies
    // row_i delayed by j with col_j delayed by i.
    function automatic logic [127:0] golden_product();
        logic [31:0] c [2][2];
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                c[i][j] = 0;
                for (int t = 0; t < 5; t++) begin
                    int ti = t - j;
                    int tj = t - i;
                    if (ti >= 0 && ti < 3 && tj >= 0 && tj < 3)
                        c[i][j] += cap_row[i][ti] * cap_col[j][tj];
                end
            end
        end
        return {c[0][0], c[0][1], c[1][0], c[1][1]};
    endfunction

    // Reference model: skew table, matrix product, and completion timing.
    task automatic push_expect(input mat_t a, input mat_t b, input int e, input int k);
        feed_t       f;
        end_t        o;
        logic [31:0] p [4];
        f.cyc = e;     f.r0 = a[0]; f.c0 = b[0]; f.r1 = 0;    f.c1 = 0;    feed_q.push_back(f);
        f.cyc = e + 1; f.r0 = a[1]; f.c0 = b[2]; f.r1 = a[2]; f.c1 = b[1]; feed_q.push_back(f);
        f.cyc = e + 2; f.r0 = 0;    f.c0 = 0;    f.r1 = a[3]; f.c1 = b[3]; feed_q.push_back(f);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                p[2*i+j] = a[2*i] * b[j] + a[2*i+1] * b[2+j];
        prod_q.push_back({p[0], p[1], p[2], p[3]});
        // 3 feed cycles, WAIT cycles numbered from 0, result one cycle later.
        if (k >= 0 && k < TIMEOUT) begin
            o.cyc = e + 4 + k; o.done = 1'b1;
        end else begin
            o.cyc = e + 3 + TIMEOUT; o.done = 1'b0;
        end
        end_q.push_back(o);
    endtask

    task automatic drive_mats(input mat_t a, input mat_t b);
        ifc.a00 = a[0]; ifc.a01 = a[1]; ifc.a10 = a[2]; ifc.a11 = a[3];
        ifc.b00 = b[0]; ifc.b01 = b[1]; ifc.b10 = b[2]; ifc.b11 = b[3];
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Present an operand pair once start_ready is seen; e = FEED0 cycle.
    task automatic start_op(input mat_t a, input mat_t b, output int e);
        int n = 0;
        @(negedge clk);
        while (ifc.start_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("start_ready_wait", ifc.start_ready, 1);
        drive_mats(a, b);
        ifc.start_valid = 1'b1;
        ifc.arr_done    = 1'($urandom_range(0, 1));  // idle: must be ignored
        e = cyc + 1;
    endtask

    // Runs one operation from FEED0; k<0 means arr_done never arrives.
    task automatic drive_op(input int e, input int k, input bit hold, input mat_t na, input mat_t nb);
        int last;
        last = (k >= 0 && k < TIMEOUT) ? e + 4 + k : e + 3 + TIMEOUT;
        @(negedge clk);
        check("busy_in_op", ifc.busy, 1);
        check("start_ready_in_op", ifc.start_ready, 0);
        ifc.start_valid = hold;
        drive_mats(na, nb);
        for (int t = 0; t < 3; t++) begin
            ifc.arr_done = 1'($urandom_range(0, 1));  // FEED cycles: ignored
            @(negedge clk);
        end
        ifc.arr_done = 1'b0;
        if (k >= 0) begin
            repeat (k) @(negedge clk);
            ifc.arr_done = 1'b1;
            @(negedge clk);
            ifc.arr_done = 1'b0;
        end
        wait_until(last + 1);
        check("busy_after_op", ifc.busy, 0);
        check("start_ready_after_op", ifc.start_ready, 1);
    endtask

    task automatic run(input mat_t a, input mat_t b, input int k);
        int e;
        start_op(a, b, e);
        push_expect(a, b, e, k);
        drive_op(e, k, 1'b0, rand_mat(), rand_mat());
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_load"}, ifc.load_in, 0);
        check({tag, "_streams"}, {ifc.row_in_row0, ifc.col_in_col0, ifc.row_in_row1, ifc.col_in_col1}, 0);
        check({tag, "_busy"}, ifc.busy, 0);
        check({tag, "_ready"}, ifc.start_ready, 1);
        check({tag, "_pulses"}, {ifc.mat_done, ifc.timeout_err}, 0);
    endtask

    // Stream monitor and golden array.
    initial begin : stream_mon
        feed_t f;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cap_n = 0;
            end else if (feed_q.size() > 0 && feed_q[0].cyc == cyc) begin
                f = feed_q.pop_front();
                check("load_in", ifc.load_in, 1);
                check("streams", {ifc.row_in_row0, ifc.col_in_col0, ifc.row_in_row1, ifc.col_in_col1},
                      {f.r0, f.c0, f.r1, f.c1});
                cap_row[0][cap_n] = ifc.row_in_row0;
                cap_row[1][cap_n] = ifc.row_in_row1;
                cap_col[0][cap_n] = ifc.col_in_col0;
                cap_col[1][cap_n] = ifc.col_in_col1;
                cap_n++;
                if (cap_n == FEED_CYCLES) begin
                    cap_n = 0;
                    check("product_pending", prod_q.size() > 0, 1);
                    if (prod_q.size() > 0) check("array_product", golden_product(), prod_q.pop_front());
                end
            end else begin
                check("idle_load", ifc.load_in, 0);
                check("idle_streams", {ifc.row_in_row0, ifc.col_in_col0, ifc.row_in_row1, ifc.col_in_col1}, 0);
            end
        end
    end

    // Completion monitor.
    initial begin : end_mon
        end_t o;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (end_q.size() > 0 && end_q[0].cyc == cyc) begin
                    o = end_q.pop_front();
                    check("mat_done", ifc.mat_done, o.done);
                    check("timeout_err", ifc.timeout_err, !o.done);
                end else begin
                    check("no_pulse", {ifc.mat_done, ifc.timeout_err}, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : main
        int   e, e2, k;
        mat_t a, b, a2, b2;

        rst = 1'b1;
        ifc.start_valid = 1'b0;
        ifc.arr_done    = 1'b0;
        drive_mats('0, '0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_quiet("reset");
        rst = 1'b1;

        // Directed product [1,2;3,4] x [5,6;7,8] = [19,22;43,50].
        run(mk(1, 2, 3, 4), mk(5, 6, 7, 8), 2);
        // Done on the 5th WAIT cycle.
        run(rand_mat(), rand_mat(), 4);
        // No done: timeout after TIMEOUT WAIT cycles.
        run(rand_mat(), rand_mat(), -1);
        // Done coincides with expiry: done wins.
        run(rand_mat(), rand_mat(), TIMEOUT - 1);

        // Reset during FEED1 aborts the operation.
        a = rand_mat(); b = rand_mat();
        start_op(a, b, e);
        begin
            feed_t f;
            f.cyc = e; f.r0 = a[0]; f.c0 = b[0]; f.r1 = 0; f.c1 = 0;
            feed_q.push_back(f);
        end
        @(negedge clk);
        ifc.start_valid = 1'b0;
        ifc.arr_done    = 1'b0;
        @(posedge clk);
        #1;
        check("load_before_rst", ifc.load_in, 1);
        rst = 1'b0;
        #1;
        check_all_quiet("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(rand_mat(), rand_mat(), 1);

        // start_valid held with new operands during an operation.
        a = rand_mat(); b = rand_mat(); a2 = rand_mat(); b2 = rand_mat();
        k = 3;
        start_op(a, b, e);
        push_expect(a, b, e, k);
        e2 = e + 6 + k;  // FIN, one IDLE cycle, then the accepting edge
        push_expect(a2, b2, e2, 2);
        drive_op(e, k, 1'b1, a2, b2);
        drive_op(e2, 2, 1'b0, rand_mat(), rand_mat());

        // Randomized operations.
        for (int i = 0; i < 12; i++) begin
            int r = $urandom_range(0, 9);
            k = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 12);
            run(rand_mat(), rand_mat(), k);
        end

        repeat (5) @(negedge clk);
        check("feed_q_drained", feed_q.size(), 0);
        check("end_q_drained", end_q.size(), 0);
        check("prod_q_drained", prod_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
